// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM block.
// Holds the microsecond time base and the command-to-pulse-width mapping.
package servo_pkg;

    localparam int unsigned US_PER_S = 1_000_000;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Product is kept at 64 bits so large spans and magnitudes cannot overflow.
    function automatic int unsigned mag_to_us(
        input longint unsigned mag,
        input int unsigned     min_us,
        input int unsigned     max_us,
        input int unsigned     mag_w
    );
        longint unsigned prod;
        prod = mag * 64'(max_us - min_us);
        return min_us + 32'(prod >> mag_w);
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler producing a one-clock tick at TICK_HZ from the CLK_HZ clock.
// The tick is decoded from the counter so it lines up with the wrap.
module servo_tick_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int unsigned CW  = (DIV <= 1) ? 1 : $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel 50 Hz servo PWM generator with per-frame commit of
// commanded widths and optional slew limiting between frames.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned MAG_W     = 13,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned SLEW_US   = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             en,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [ch_width(NUM_CH)-1:0]   cmd_ch,
    input  logic [MAG_W-1:0]              cmd_mag,
    output logic                          cmd_err,
    output logic [NUM_CH-1:0]             pwm,
    output logic                          frame_start
);

    localparam int unsigned TW = $clog2(MAX_US + 1);
    localparam int unsigned FW = (PERIOD_US <= 1) ? 1 : $clog2(PERIOD_US);

    logic              tick;
    logic              wrap;
    logic              commit;
    logic              xfer;
    logic              ch_ok;
    int unsigned       ch_i;
    int unsigned       t_us;
    int unsigned       a_us;
    int unsigned       diff;
    logic [TW-1:0]     cmd_us;

    logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [TW-1:0]     target_q [NUM_CH];
    logic [TW-1:0]     target_d [NUM_CH];
    logic [TW-1:0]     active_q [NUM_CH];
    logic [TW-1:0]     active_d [NUM_CH];

    servo_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (US_PER_S)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    assign wrap        = tick && (frame_cnt_q == FW'(PERIOD_US - 1));
    assign commit      = wrap && reset_n;
    assign frame_start = commit;
    // Commands are refused only while the frame is being committed.
    assign cmd_ready   = reset_n && !wrap;
    assign cmd_err     = err_q;
    assign pwm         = pwm_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_d       = 1'b0;
        pwm_d       = '0;
        target_d    = target_q;
        active_d    = active_q;
        ch_i        = 32'(cmd_ch);
        ch_ok       = (ch_i < NUM_CH);
        xfer        = cmd_valid && cmd_ready;
        cmd_us      = TW'(mag_to_us(64'(cmd_mag), MIN_US, MAX_US, MAG_W));
        t_us        = 0;
        a_us        = 0;
        diff        = 0;

        if (tick) begin
            frame_cnt_d = wrap ? '0 : frame_cnt_q + FW'(1);
        end

        err_d = xfer && !ch_ok;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (xfer && ch_ok && (ch_i == i)) begin
                target_d[i] = cmd_us;
            end
            pwm_d[i] = en[i] && (32'(frame_cnt_q) < 32'(active_q[i]));
        end

        if (commit) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                t_us = 32'(target_q[i]);
                a_us = 32'(active_q[i]);
                diff = (t_us >= a_us) ? t_us - a_us : a_us - t_us;
                if (SLEW_US == 0 || diff <= SLEW_US) begin
                    active_d[i] = target_q[i];
                end else if (t_us > a_us) begin
                    active_d[i] = TW'(a_us + SLEW_US);
                end else begin
                    active_d[i] = TW'(a_us - SLEW_US);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            pwm_q       <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                target_q[i] <= TW'(MIN_US);
                active_q[i] <= TW'(MIN_US);
            end
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            pwm_q       <= pwm_d;
            target_q    <= target_d;
            active_q    <= active_d;
        end
    end

endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, input clock frequency in Hz.
REQ-002 Parameter NUM_CH, 4, number of independent servo channels (1..16).
REQ-003 Parameter MAG_W, 13, command magnitude width in bits.
REQ-004 Parameter PERIOD_US, 20000, PWM frame period in microseconds (50 Hz).
REQ-005 Parameter MIN_US, 1000, pulse width for magnitude 0.
REQ-006 Parameter MAX_US, 2000, full-scale pulse width (exclusive upper bound).
REQ-007 Parameter SLEW_US, 0, maximum pulse-width change per frame in us; 0 disables slew limiting.
REQ-008 Port clk, input, 1, system clock; all logic on rising edge.
REQ-009 Port reset_n, input, 1, synchronous active-low reset.
REQ-010 Port en, input, NUM_CH, per-channel output enable.
REQ-011 Port cmd_valid, input, 1, command present.
REQ-012 Port cmd_ready, output, 1, block can accept a command this cycle.
REQ-013 Port cmd_ch, input, $clog2(NUM_CH) (min 1), target channel index.
REQ-014 Port cmd_mag, input, MAG_W, requested position magnitude.
REQ-015 Port cmd_err, output, 1, one-cycle pulse: accepted command had cmd_ch >= NUM_CH.
REQ-016 Port pwm, output, NUM_CH, servo pulse outputs.
REQ-017 Port frame_start, output, 1, one-cycle pulse at start of each frame.

Function
REQ-018 Tick generator SHALL pulse tick for one clk every CLK_HZ/1_000_000 cycles (1 us).
REQ-019 Frame counter SHALL increment on tick, range 0..PERIOD_US-1, then wrap to 0.
REQ-020 Commit cycle = clk cycle where tick is high and frame counter wraps to 0; frame_start SHALL be high exactly in that cycle.
REQ-021 Command transfer SHALL occur when cmd_valid && cmd_ready; cmd_ready SHALL be 1 in every cycle except commit cycles.
REQ-022 Transfer with cmd_ch < NUM_CH SHALL write target[cmd_ch] = MIN_US + ((cmd_mag * (MAX_US-MIN_US)) >> MAG_W), computed at full width with no overflow.
REQ-023 Transfer with cmd_ch >= NUM_CH SHALL change no state and SHALL assert cmd_err the next cycle.
REQ-024 Multiple transfers to one channel within a frame: last one wins.
REQ-025 On commit cycle, per channel: SLEW_US=0 or |target-active| <= SLEW_US -> active=target; else active moves SLEW_US toward target.
REQ-026 active[i] SHALL change only on commit cycles (glitch-free, no mid-frame width change).
REQ-027 pwm[i] SHALL be a registered en[i] && (frame_cnt < active[i]), 1-clk latency from counter; en[i]=0 forces low next cycle.
REQ-028 Pulse high time SHALL equal active[i] us +/- 1 clk.

Reset
REQ-029 While reset_n=0 at a clk edge: pwm=0, frame_start=0, cmd_err=0, cmd_ready=0, frame counter=0, prescaler=0, target[i]=active[i]=MIN_US.
REQ-030 First cycle after reset release: cmd_ready=1; first frame begins with frame counter 0 and no commit until the first wrap.
REQ-031 Reset asserted mid-frame or mid-pulse SHALL abort immediately; no partial pulse after release.

Structure
REQ-032 Package servo_pkg SHALL hold US_PER_S constant, width helper for channel index, and the magnitude-to-microseconds mapping function.
REQ-033 Prescaler SHALL be sub-module servo_tick_gen (params CLK_HZ, TICK_HZ; ports clk, reset_n, tick).
REQ-034 Per-channel target/active SHALL be arrays indexed by channel, width $clog2(MAX_US+1).

Verification
REQ-035 Defaults, reset then write ch0 mag=4096, en=1 -> from second frame_start, pwm[0] high 75000 clks every 1_000_000 clks.
REQ-036 Write ch1 mag=0 and ch1 mag=8191 in same frame -> ch1 pulse 1999 us next frame (last wins); others stay at 1000 us.
REQ-037 SLEW_US=100, ch2 active 1000 then mag=8191 -> pulse widths 1100,1200,...,1900,1999 over ten successive frames.
REQ-038 cmd_valid held high across a commit -> cmd_ready low only in commit cycle; cmd_ch=NUM_CH -> cmd_err 1-cycle pulse, no width change.
REQ-039 reset_n low during ch0 pulse -> pwm[0] low next edge; after release widths 1000 us and frame counter restarts at 0.
